vector_dispatch_queue: RTL and testbench
========================================

# vector_dispatch_queue

Buffers vector instructions retired by the single-cycle scalar core and hands them, with their scalar operands, to the vector unit over a valid/ready handshake. It sits directly downstream of the core's controller and register file, consuming `is_vector`, the instruction word and the two register-file read values. It drives the core's `pc_enable` to stall fetch when the queue is full, or when a scalar fence must wait for the vector side to go quiet.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; must be a power of two and ≥ 2.
- `CNTW`, default `$clog2(DEPTH)+1`: derived width of `count`; not overridden.

Ports:
- `clk`: in, 1. Single clock; all state updates on the rising edge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `is_vector`: in, 1. The current core instruction is a vector op.
- `instruction`: in, 32. Current core instruction word.
- `rdataA`: in, 32. Scalar operand from register-file port A (rs1).
- `rdataB`: in, 32. Scalar operand from register-file port B (rs2).
- `fence_i`: in, 1. The current scalar instruction requires vector quiescence before it retires.
- `flush`: in, 1. Synchronous clear of the queue and state machine.
- `pc_enable`: out, 1. Core advance enable; low means stall.
- `vec_valid`: out, 1. The head entry is valid.
- `vec_ready`: in, 1. The vector unit accepts the head entry.
- `vec_instr`: out, 32. Head entry instruction.
- `vec_rs1`: out, 32. Head entry rs1 value.
- `vec_rs2`: out, 32. Head entry rs2 value.
- `vec_busy`: in, 1. The vector unit has work in flight.
- `count`: out, CNTW. Number of occupied entries, 0 to DEPTH.

## Operation
- **Storage:** circular buffer of DEPTH entries, each {instruction, rdataA, rdataB}. Write and read pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is a separate register.
- **Enqueue:** occurs when `is_vector && pc_enable`. It writes at the write pointer, then the write pointer increments.
- **Dequeue:** occurs when `vec_valid && vec_ready`. The read pointer increments.
- **Head outputs:** `vec_valid` = (`count != 0`). `vec_instr`, `vec_rs1` and `vec_rs2` show the entry at the read pointer. When empty they show stale data, and the consumer must ignore them.
- **Count update:**
  - Enqueue alone: +1.
  - Dequeue alone: −1.
  - Both in the same cycle: unchanged, and both pointers advance.
- **Full stall:** `pc_enable` is low when `is_vector && count == DEPTH`. There is no full-bypass, because `vec_ready` never reaches `pc_enable` combinationally.
- **Fence FSM:** two states, RUN (reset state) and DRAIN.
  - `quiet` = (`count == 0 && !vec_busy`).
  - RUN: if `fence_i && !is_vector && !quiet`, go to DRAIN and hold `pc_enable` low. Otherwise stay in RUN.
  - DRAIN: `pc_enable` is low. When `quiet`, go to RUN. The fence then retires in RUN on the next cycle because `quiet` still holds.
  - `fence_i` is ignored when `is_vector` is high.
- **`pc_enable` summary:** `pc_enable` = !(full stall) && !(state == DRAIN) && !(RUN && `fence_i` && !`is_vector` && !`quiet`).
- **Flush:** takes priority over enqueue and dequeue in the same cycle. It clears the pointers and `count`, forces RUN, and leaves storage contents untouched. `pc_enable` is computed combinationally as normal during the flush cycle, but no enqueue is recorded.

## Timing
- **Reset values:** pointers 0, `count` 0, state RUN, storage entries 0. Outputs under reset:
  - `vec_valid` = 0.
  - `vec_instr`, `vec_rs1`, `vec_rs2` = 0.
  - `count` = 0.
  - `pc_enable` = 1 unless `fence_i && !is_vector && vec_busy`.
- **Enqueue to valid latency:** 1 cycle. An instruction enqueued at edge N is visible with `vec_valid` = 1 after edge N.
- **Full recovery:** with the queue full and `is_vector` high, a dequeue at edge N makes `pc_enable` = 1 in cycle N+1, and the enqueue happens at edge N+1.
- **Handshake:** `vec_valid` never drops without a dequeue or a flush. Head data is stable while `vec_valid && !vec_ready`.
- **Pointer wrap:** pointers wrap from DEPTH−1 to 0 with no bubble.
- **Async reset mid-operation:** the queue empties immediately. Entries in flight are lost, and the core is responsible for re-issuing them.

## Test plan
- **Reset:** assert `rst` while `count` = 3 → next cycle `count` = 0, `vec_valid` = 0, `pc_enable` = 1.
- **Fill and stall (DEPTH = 4):** hold `vec_ready` = 0 and issue 5 vector instructions 0x00000057 + k → `count` reaches 4, `pc_enable` goes to 0 on the 5th. Raise `vec_ready` for 1 cycle → the head is 0x00000057, and the 5th instruction enqueues on the next cycle.
- **Simultaneous enqueue/dequeue:** at `count` = 2 with `vec_ready` = 1 and `is_vector` = 1 for 6 cycles → `count` stays 2 and pointers wrap. Output order matches input order.
- **Fence drain:** `count` = 2, `vec_busy` = 1, then assert `fence_i` with a scalar instruction → `pc_enable` = 0. Drain both entries, then drop `vec_busy` → state returns to RUN and `pc_enable` = 1 exactly one cycle after `quiet` is first seen.
- **Flush with ready:** assert `flush` with `count` = 3 and `vec_ready` = 1 → next cycle `count` = 0, `vec_valid` = 0, state RUN.
- **Fence ignored on vector instruction:** `is_vector` = 1 and `fence_i` = 1 with `vec_busy` = 1 → no DRAIN entry, and the instruction enqueues.

Source files
------------

// File: rtl/vector_dispatch_queue.sv
// Vector instruction dispatch queue between the scalar core and the vector unit.
// Buffers {instruction, rs1, rs2}, stalls fetch when full or while a fence drains.
//
// state | meaning
// RUN   | normal issue; a scalar fence seen with vector work pending moves to DRAIN
// DRAIN | fetch held until the queue is empty and the vector unit is idle
module vector_dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_vector,
    input  logic [31:0]     instruction,
    input  logic [31:0]     rdataA,
    input  logic [31:0]     rdataB,
    input  logic            fence_i,
    input  logic            flush,
    output logic            pc_enable,
    output logic            vec_valid,
    input  logic            vec_ready,
    output logic [31:0]     vec_instr,
    output logic [31:0]     vec_rs1,
    output logic [31:0]     vec_rs2,
    input  logic            vec_busy,
    output logic [CNTW-1:0] count
);

    localparam int PTRW = $clog2(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     mem_instr [DEPTH];
    logic [31:0]     mem_rs1   [DEPTH];
    logic [31:0]     mem_rs2   [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count_q;
    logic            full;
    logic            quiet;
    logic            enq;
    logic            deq;

    assign full      = (count_q == CNTW'(DEPTH));
    assign quiet     = (count_q == '0) && !vec_busy;
    assign vec_valid = (count_q != '0);
    assign count     = count_q;
    assign vec_instr = mem_instr[rd_ptr];
    assign vec_rs1   = mem_rs1[rd_ptr];
    assign vec_rs2   = mem_rs2[rd_ptr];

    // Flush wins over both handshakes; storage is left as-is on flush.
    assign enq = is_vector && pc_enable && !flush;
    assign deq = vec_valid && vec_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_rs1[i]   <= '0;
                mem_rs2[i]   <= '0;
            end
        end else if (enq) begin
            mem_instr[wr_ptr] <= instruction;
            mem_rs1[wr_ptr]   <= rdataA;
            mem_rs2[wr_ptr]   <= rdataB;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A vector op carrying fence_i is treated as a plain vector op.
    always_comb begin
        state_nxt = state;
        pc_enable = !(is_vector && full);
        case (state)
            RUN: begin
                if (fence_i && !is_vector && !quiet) begin
                    state_nxt = DRAIN;
                    pc_enable = 1'b0;
                end
            end
            DRAIN: begin
                pc_enable = 1'b0;
                if (quiet) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (flush) begin
            state_nxt = RUN;
        end
    end

endmodule

// File: tb/tb_vector_dispatch_queue.sv
// Directed table-driven bench for vector_dispatch_queue (DEPTH = 4), plus
// hand-written reset sequences.
module tb_vector_dispatch_queue;

    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            is_vector;
    logic [31:0]     instruction;
    logic [31:0]     rdataA;
    logic [31:0]     rdataB;
    logic            fence_i;
    logic            flush;
    logic            pc_enable;
    logic            vec_valid;
    logic            vec_ready;
    logic [31:0]     vec_instr;
    logic [31:0]     vec_rs1;
    logic [31:0]     vec_rs2;
    logic            vec_busy;
    logic [CNTW-1:0] count;

    int pass_cnt = 0;
    int total    = 0;

    vector_dispatch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_vector  (is_vector),
        .instruction(instruction),
        .rdataA     (rdataA),
        .rdataB     (rdataB),
        .fence_i    (fence_i),
        .flush      (flush),
        .pc_enable  (pc_enable),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_instr  (vec_instr),
        .vec_rs1    (vec_rs1),
        .vec_rs2    (vec_rs2),
        .vec_busy   (vec_busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle and outputs expected in that cycle, before its edge.
    typedef struct {
        logic        is_v;
        logic [31:0] instr;
        logic        fence;
        logic        fl;
        logic        rdy;
        logic        busy;
        logic        exp_pc;
        logic        exp_valid;
        int          exp_count;
        logic        chk_head;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic is_v, input logic [31:0] instr,
                                input logic fence, input logic fl, input logic rdy,
                                input logic busy, input logic exp_pc,
                                input logic exp_valid, input int exp_count,
                                input logic chk_head, input logic [31:0] exp_instr);
        vec_t v;
        v.is_v = is_v;   v.instr = instr;   v.fence = fence; v.fl = fl;
        v.rdy = rdy;     v.busy = busy;     v.exp_pc = exp_pc;
        v.exp_valid = exp_valid;            v.exp_count = exp_count;
        v.chk_head = chk_head;              v.exp_instr = exp_instr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic is_v, input logic [31:0] instr, input logic fence,
                         input logic fl, input logic rdy, input logic busy);
        is_vector   = is_v;
        instruction = instr;
        rdataA      = instr + 32'h100;
        rdataB      = instr + 32'h200;
        fence_i     = fence;
        flush       = fl;
        vec_ready   = rdy;
        vec_busy    = busy;
    endtask

    task automatic check_outputs(input string tag, input logic e_pc, input logic e_valid,
                                 input int e_count, input logic chk_head,
                                 input logic [31:0] e_instr);
        check({tag, " pc_enable"}, 32'(pc_enable), 32'(e_pc));
        check({tag, " vec_valid"}, 32'(vec_valid), 32'(e_valid));
        check({tag, " count"}, 32'(count), 32'(e_count));
        if (chk_head) begin
            check({tag, " vec_instr"}, vec_instr, e_instr);
            check({tag, " vec_rs1"}, vec_rs1, e_instr + 32'h100);
            check({tag, " vec_rs2"}, vec_rs2, e_instr + 32'h200);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // fill to full, stall on the 5th, one-cycle dequeue releases it
        tbl.push_back(mk(1, 32'h57, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h58, 0, 0, 0, 0, 1, 1, 1, 1, 32'h57));
        tbl.push_back(mk(1, 32'h59, 0, 0, 0, 0, 1, 1, 2, 1, 32'h57));
        tbl.push_back(mk(1, 32'h5A, 0, 0, 0, 0, 1, 1, 3, 1, 32'h57));
        tbl.push_back(mk(1, 32'h5B, 0, 0, 0, 0, 0, 1, 4, 1, 32'h57));
        tbl.push_back(mk(1, 32'h5B, 0, 0, 1, 0, 0, 1, 4, 1, 32'h57));
        tbl.push_back(mk(1, 32'h5B, 0, 0, 0, 0, 1, 1, 3, 1, 32'h58));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 1, 1, 4, 1, 32'h58));
        // drain to 2, then six simultaneous enqueue/dequeue cycles across the wrap
        tbl.push_back(mk(0, 32'h0,  0, 0, 1, 0, 1, 1, 4, 1, 32'h58));
        tbl.push_back(mk(0, 32'h0,  0, 0, 1, 0, 1, 1, 3, 1, 32'h59));
        tbl.push_back(mk(1, 32'h60, 0, 0, 1, 0, 1, 1, 2, 1, 32'h5A));
        tbl.push_back(mk(1, 32'h61, 0, 0, 1, 0, 1, 1, 2, 1, 32'h5B));
        tbl.push_back(mk(1, 32'h62, 0, 0, 1, 0, 1, 1, 2, 1, 32'h60));
        tbl.push_back(mk(1, 32'h63, 0, 0, 1, 0, 1, 1, 2, 1, 32'h61));
        tbl.push_back(mk(1, 32'h64, 0, 0, 1, 0, 1, 1, 2, 1, 32'h62));
        tbl.push_back(mk(1, 32'h65, 0, 0, 1, 0, 1, 1, 2, 1, 32'h63));
        // fence drain: stall until empty and idle, release one cycle after quiet
        tbl.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 1, 2, 1, 32'h64));
        tbl.push_back(mk(0, 32'h0,  1, 0, 1, 1, 0, 1, 2, 1, 32'h64));
        tbl.push_back(mk(0, 32'h0,  1, 0, 1, 1, 0, 1, 1, 1, 32'h65));
        tbl.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,  1, 0, 0, 0, 1, 0, 0, 0, 32'h0));
        // fence on a vector op is ignored and the op enqueues
        tbl.push_back(mk(1, 32'h70, 1, 0, 0, 1, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h71, 0, 0, 0, 1, 1, 1, 1, 1, 32'h70));
        tbl.push_back(mk(1, 32'h72, 0, 0, 0, 1, 1, 1, 2, 1, 32'h70));
        // flush at count 3 with ready and a concurrent vector op: nothing recorded
        tbl.push_back(mk(1, 32'h73, 0, 1, 1, 0, 1, 1, 3, 1, 32'h70));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 1, 0, 0, 0, 32'h0));
        // flush while in DRAIN returns to RUN
        tbl.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 1, 0, 0, 0, 32'h0));

        // outputs under reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs("in_reset", 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("in_reset vec_instr", vec_instr, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("in_reset fence_busy pc_enable", 32'(pc_enable), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].is_v, tbl[i].instr, tbl[i].fence, tbl[i].fl, tbl[i].rdy, tbl[i].busy);
            #1;
            check_outputs($sformatf("row%0d", i), tbl[i].exp_pc, tbl[i].exp_valid,
                          tbl[i].exp_count, tbl[i].chk_head, tbl[i].exp_instr);
        end

        // async reset mid-operation at count 3
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h80 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outputs("pre_reset", 1'b1, 1'b1, 3, 1'b1, 32'h80);
        #1;
        rst = 1'b1;
        #1;
        check_outputs("async_reset", 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("async_reset vec_instr", vec_instr, 32'h0);
        check("async_reset vec_rs1", vec_rs1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_reset", 1'b1, 1'b0, 0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'h90, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outputs("reenqueue", 1'b1, 1'b1, 1, 1'b1, 32'h90);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
